// File: rtl/bus_rr_arbiter_bcast.sv
// -----------------------------------------------------------------------------
// bus_rr_arbiter_bcast
//
// Moves packets between drvrs device FIFOs over one shared bus. Each transfer
// takes three cycles: IDLE picks a source, POP consumes that source's FIFO
// head, PUSH delivers the packet to its destination. The destination is one
// device, all devices except the source (broadcast), or nobody when the
// destination field is out of range. Out-of-range packets are counted in a
// saturating drop counter.
//
// Ports
//   clk        : clock, all state changes on posedge
//   reset      : asynchronous, active-low
//   pndng      : per-device "FIFO non-empty"; the head word is valid on D_pop
//   D_pop      : flattened FIFO heads, device i at [i*pckg_sz +: pckg_sz]
//   pop        : one-hot, one-cycle pulse consuming the head of device i
//   push       : one-/multi-hot, one-cycle pulse writing D_push into device j
//   D_push     : packet on the bus; meaningful only where push is set
//   grant_vld  : high during POP and PUSH
//   grant_id   : current or most recent source index
//   drop_cnt   : saturating count of dropped packets
//   dbg_state  : FSM state (0 IDLE, 1 POP, 2 PUSH)
//
// Handshake: pndng[i] is a level meaning "device i has a word at its head".
// A one-cycle pop[i] consumes that word at the end of the cycle in which pop
// is high. A one-cycle push[j] means device j must take D_push at the end of
// that cycle. There is no back-pressure on push.
// -----------------------------------------------------------------------------
module bus_rr_arbiter_bcast #(
   parameter int              drvrs     = 4,
   parameter int              pckg_sz   = 16,
   parameter int              ID_W      = 8,
   parameter logic [ID_W-1:0] broadcast = {ID_W{1'b1}},
   parameter int              ARB_MODE  = 1,
   parameter int              CNT_W     = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [drvrs-1:0]           pndng,
   input  logic [drvrs*pckg_sz-1:0]   D_pop,
   output logic [drvrs-1:0]           pop,
   output logic [drvrs-1:0]           push,
   output logic [pckg_sz-1:0]         D_push,
   output logic                       grant_vld,
   output logic [$clog2(drvrs)-1:0]   grant_id,
   output logic [CNT_W-1:0]           drop_cnt,
   output logic [1:0]                 dbg_state
);

   localparam int GID_W = $clog2(drvrs);
   localparam logic [drvrs-1:0] ONE_HOT0 = {{(drvrs-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_POP  = 2'd1,
      S_PUSH = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [drvrs-1:0]     pop_q, pop_d;
   logic [drvrs-1:0]     push_q, push_d;
   logic [pckg_sz-1:0]   d_push_q, d_push_d;
   logic                 grant_vld_q, grant_vld_d;
   logic [GID_W-1:0]     grant_id_q, grant_id_d;
   logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
   logic [GID_W-1:0]     rr_ptr_q, rr_ptr_d;

   logic [GID_W-1:0]     win_idx;
   int                   rr_idx;
   logic [pckg_sz-1:0]   head;
   logic [ID_W-1:0]      dest;

   // Winner search. Loops run from the far end downwards so that the
   // candidate closest to the start of the search is the last assignment.
   always_comb begin
      win_idx = '0;
      rr_idx  = 0;
      if (ARB_MODE == 0) begin
         for (int i = drvrs - 1; i >= 0; i--) begin
            if (pndng[i]) win_idx = GID_W'(i);
         end
      end else begin
         for (int k = drvrs - 1; k >= 0; k--) begin
            rr_idx = int'(rr_ptr_q) + k;
            if (rr_idx >= drvrs) rr_idx = rr_idx - drvrs;
            if (pndng[rr_idx]) win_idx = GID_W'(rr_idx);
         end
      end
   end

   // The packet is decoded while it is still on D_pop during POP, so that
   // push, D_push and drop_cnt can all be registered into the PUSH cycle.
   assign head = D_pop[int'(grant_id_q)*pckg_sz +: pckg_sz];
   assign dest = head[pckg_sz-1 -: ID_W];

   always_comb begin
      state_d     = state_q;
      pop_d       = '0;
      push_d      = '0;
      d_push_d    = d_push_q;
      grant_vld_d = grant_vld_q;
      grant_id_d  = grant_id_q;
      drop_cnt_d  = drop_cnt_q;
      rr_ptr_d    = rr_ptr_q;

      case (state_q)
         S_IDLE: begin
            if (|pndng) begin
               grant_id_d  = win_idx;
               grant_vld_d = 1'b1;
               pop_d       = ONE_HOT0 << win_idx;
               if (int'(win_idx) == drvrs - 1) rr_ptr_d = '0;
               else                            rr_ptr_d = win_idx + GID_W'(1);
               state_d     = S_POP;
            end
         end
         S_POP: begin
            d_push_d = head;
            if (dest == broadcast) begin
               push_d = ~(ONE_HOT0 << grant_id_q);
            end else if (int'(dest) < drvrs) begin
               push_d = ONE_HOT0 << dest;
            end else if (drop_cnt_q != {CNT_W{1'b1}}) begin
               drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
            state_d = S_PUSH;
         end
         S_PUSH: begin
            grant_vld_d = 1'b0;
            state_d     = S_IDLE;
         end
         default: begin
            grant_vld_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         pop_q       <= '0;
         push_q      <= '0;
         d_push_q    <= '0;
         grant_vld_q <= 1'b0;
         grant_id_q  <= '0;
         drop_cnt_q  <= '0;
         rr_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         pop_q       <= pop_d;
         push_q      <= push_d;
         d_push_q    <= d_push_d;
         grant_vld_q <= grant_vld_d;
         grant_id_q  <= grant_id_d;
         drop_cnt_q  <= drop_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign pop       = pop_q;
   assign push      = push_q;
   assign D_push    = d_push_q;
   assign grant_vld = grant_vld_q;
   assign grant_id  = grant_id_q;
   assign drop_cnt  = drop_cnt_q;
   assign dbg_state = state_q;

endmodule
